vga_layer_mixer: RTL and testbench



---
 rtl/vga_mix_pkg.sv | 16 +
 rtl/vga_fade_ctrl.sv | 122 ++++++++++++
 rtl/vga_layer_mixer.sv | 118 +++++++++++
 tb/tb_vga_layer_mixer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mix_pkg.sv
// Shared types and constants for the VGA layer mixer: fade FSM states and
// brightness / channel widths.
package vga_mix_pkg;

    typedef enum logic [1:0] {
        FULL     = 2'd0,
        FADE_OUT = 2'd1,
        DARK     = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    localparam int BRIGHT_W = 5;
    localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = 5'd16;
    localparam int CH_W = 4;

endpackage

// File: rtl/vga_fade_ctrl.sv
// Frame-tick detector, fade FSM with step counter and brightness register.
// With VGA_BLINK_EN defined, also a blink phase for layer 0.
module vga_fade_ctrl
    import vga_mix_pkg::*;
#(
    parameter int FADE_STEP_FRAMES = 2
`ifdef VGA_BLINK_EN
    , parameter int BLINK_FRAMES = 30
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_vsync,
    input  logic                i_fade_start,
    output logic [BRIGHT_W-1:0] o_bright,
    output logic                o_fade_busy,
    output logic                o_blink_hide
);

    localparam logic [7:0] STEP_LAST = 8'(FADE_STEP_FRAMES - 1);

    logic                r_vsync_d;
    logic                w_tick;
    fade_state_t         r_state;
    fade_state_t         w_state_nx;
    logic [7:0]          r_step;
    logic [7:0]          w_step_nx;
    logic [BRIGHT_W-1:0] r_bright;
    logic [BRIGHT_W-1:0] w_bright_nx;
    logic                r_busy;

    // Falling edge of vsync marks the start of a new frame.
    assign w_tick = r_vsync_d & ~i_vsync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d <= 1'b1;
            r_state   <= FULL;
            r_step    <= '0;
            r_bright  <= BRIGHT_MAX;
            r_busy    <= 1'b0;
        end else begin
            r_vsync_d <= i_vsync;
            r_state   <= w_state_nx;
            r_step    <= w_step_nx;
            r_bright  <= w_bright_nx;
            r_busy    <= (w_state_nx == FADE_OUT) || (w_state_nx == FADE_IN);
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_step_nx   = r_step;
        w_bright_nx = r_bright;
        unique case (r_state)
            FULL: begin
                if (i_fade_start) begin
                    w_state_nx = FADE_OUT;
                    w_step_nx  = '0;
                end
            end
            DARK: begin
                if (i_fade_start) begin
                    w_state_nx = FADE_IN;
                    w_step_nx  = '0;
                end
            end
            FADE_OUT: begin
                if (w_tick) begin
                    if (r_step == STEP_LAST) begin
                        w_step_nx   = '0;
                        w_bright_nx = r_bright - 1'b1;
                        if (r_bright == BRIGHT_W'(1)) w_state_nx = DARK;
                    end else begin
                        w_step_nx = r_step + 1'b1;
                    end
                end
            end
            FADE_IN: begin
                if (w_tick) begin
                    if (r_step == STEP_LAST) begin
                        w_step_nx   = '0;
                        w_bright_nx = r_bright + 1'b1;
                        if (r_bright == BRIGHT_MAX - 1'b1) w_state_nx = FULL;
                    end else begin
                        w_step_nx = r_step + 1'b1;
                    end
                end
            end
            default: w_state_nx = FULL;
        endcase
    end

    assign o_bright    = r_bright;
    assign o_fade_busy = r_busy;

`ifdef VGA_BLINK_EN
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

    logic [15:0] r_blink_cnt;
    logic        r_blink_hide;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt  <= '0;
            r_blink_hide <= 1'b0;
        end else if (w_tick) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt  <= '0;
                r_blink_hide <= ~r_blink_hide;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign o_blink_hide = r_blink_hide;
`else
    assign o_blink_hide = 1'b0;
`endif

endmodule

// File: rtl/vga_layer_mixer.sv
// Priority layer mixer with colour-key transparency, fade brightness and 2-cycle sync delay.
// Optional layer-0 blink when VGA_BLINK_EN is defined.
module vga_layer_mixer
    import vga_mix_pkg::*;
#(
    parameter int                 NUM_LAYERS       = 4,
    parameter int                 COLOR_W          = 12,
    parameter logic [COLOR_W-1:0] BG_COLOR         = 12'h000,
    parameter int                 FADE_STEP_FRAMES = 2
`ifdef VGA_BLINK_EN
    , parameter int               BLINK_FRAMES     = 30
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [COLOR_W-1:0]            trans_key,
    input  logic                          video_on_in,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic                          fade_start,
    output logic                          fade_busy,
    output logic [CH_W-1:0]               VGA_R,
    output logic [CH_W-1:0]               VGA_G,
    output logic [CH_W-1:0]               VGA_B,
    output logic                          hsync_out,
    output logic                          vsync_out
);

    function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] ch,
                                                 input logic [BRIGHT_W-1:0] br);
        logic [8:0] prod;
        prod = 9'(ch) * 9'(br);
        return CH_W'(prod >> 4);
    endfunction

    logic [BRIGHT_W-1:0] w_bright;
    logic                w_blink_hide;
    logic [COLOR_W-1:0]  w_win_color;

    logic [COLOR_W-1:0]  r_color_p0;
    logic                r_vld_p0;
    logic                r_hs_p0;
    logic                r_vs_p0;

    logic [CH_W-1:0]     r_r_p1;
    logic [CH_W-1:0]     r_g_p1;
    logic [CH_W-1:0]     r_b_p1;
    logic                r_hs_p1;
    logic                r_vs_p1;

    vga_fade_ctrl #(
        .FADE_STEP_FRAMES(FADE_STEP_FRAMES)
`ifdef VGA_BLINK_EN
        , .BLINK_FRAMES(BLINK_FRAMES)
`endif
    ) u_fade (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_vsync     (vsync_in),
        .i_fade_start(fade_start),
        .o_bright    (w_bright),
        .o_fade_busy (fade_busy),
        .o_blink_hide(w_blink_hide)
    );

    // Scan from lowest priority upward so the lowest eligible index wins last.
    always_comb begin
        w_win_color = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_en[i] &&
                (layer_color[i*COLOR_W +: COLOR_W] != trans_key) &&
                ((i != 0) || !w_blink_hide)) begin
                w_win_color = layer_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    // Stage A: winner colour and timing flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_color_p0 <= '0;
            r_vld_p0   <= 1'b0;
            r_hs_p0    <= 1'b1;
            r_vs_p0    <= 1'b1;
        end else begin
            r_color_p0 <= w_win_color;
            r_vld_p0   <= video_on_in;
            r_hs_p0    <= hsync_in;
            r_vs_p0    <= vsync_in;
        end
    end

    // Stage B: brightness scaling and blanking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r_p1  <= '0;
            r_g_p1  <= '0;
            r_b_p1  <= '0;
            r_hs_p1 <= 1'b1;
            r_vs_p1 <= 1'b1;
        end else begin
            r_r_p1  <= r_vld_p0 ? scale_ch(r_color_p0[COLOR_W-1 -: CH_W], w_bright) : '0;
            r_g_p1  <= r_vld_p0 ? scale_ch(r_color_p0[2*CH_W-1 -: CH_W], w_bright) : '0;
            r_b_p1  <= r_vld_p0 ? scale_ch(r_color_p0[CH_W-1:0], w_bright) : '0;
            r_hs_p1 <= r_hs_p0;
            r_vs_p1 <= r_vs_p0;
        end
    end

    assign VGA_R     = r_r_p1;
    assign VGA_G     = r_g_p1;
    assign VGA_B     = r_b_p1;
    assign hsync_out = r_hs_p1;
    assign vsync_out = r_vs_p1;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed self-checking bench for vga_layer_mixer (BG_COLOR = 12'h00F, FADE_STEP_FRAMES = 2).
// Define VGA_BLINK_EN to build with BLINK_FRAMES = 3 and run the blink scenario.
module tb_vga_layer_mixer;

    logic        clk;
    logic        rst_n;
    logic [47:0] layer_color;
    logic [3:0]  layer_en;
    logic [11:0] trans_key;
    logic        video_on_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        fade_start;
    logic        fade_busy;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;
    logic        hsync_out;
    logic        vsync_out;

    int checks = 0;
    int errors = 0;

    vga_layer_mixer #(
        .NUM_LAYERS      (4),
        .COLOR_W         (12),
        .BG_COLOR        (12'h00F),
        .FADE_STEP_FRAMES(2)
`ifdef VGA_BLINK_EN
        , .BLINK_FRAMES  (3)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .layer_color(layer_color),
        .layer_en   (layer_en),
        .trans_key  (trans_key),
        .video_on_in(video_on_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .fade_start (fade_start),
        .fade_busy  (fade_busy),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_ticks(input int n);
        repeat (n) begin
            vsync_in = 1'b0;
            cycles(1);
            vsync_in = 1'b1;
            cycles(1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fade_start = 1'b0;
        vsync_in = 1'b1;
        hsync_in = 1'b1;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        layer_color = {12'h00F, 12'h0F0, 12'hF00, 12'hFFF};
        layer_en = 4'b1111;
        trans_key = 12'h000;
        video_on_in = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        fade_start = 1'b0;
        cycles(2);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin
            errors++;
            $display("FAIL reset_rgb: got %h expected %h", {VGA_R, VGA_G, VGA_B}, 12'h000);
        end
        checks++;
        if (hsync_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_hsync: got %b expected 1", hsync_out);
        end
        checks++;
        if (vsync_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_vsync: got %b expected 1", vsync_out);
        end
        checks++;
        if (fade_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", fade_busy);
        end
        rst_n = 1'b1;
        checks++;
        if (hsync_out !== 1'b1) begin
            errors++;
            $display("FAIL release_hsync_c0: got %b expected 1", hsync_out);
        end
        cycles(1);
        checks++;
        if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
            errors++;
            $display("FAIL release_sync_c1: got %b%b expected 11", hsync_out, vsync_out);
        end
        cycles(1);
        checks++;
        if (hsync_out !== 1'b0 || vsync_out !== 1'b0) begin
            errors++;
            $display("FAIL release_sync_c2: got %b%b expected 00", hsync_out, vsync_out);
        end
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        cycles(2);
    endtask

    task automatic test_priority();
        trans_key = 12'h000;
        video_on_in = 1'b1;
        layer_color = {12'h00F, 12'h0F0, 12'hF00, 12'h000};
        layer_en = 4'b1111;
        cycles(2);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'hF00) begin
            errors++;
            $display("FAIL prio_l1: got %h expected %h", {VGA_R, VGA_G, VGA_B}, 12'hF00);
        end
        layer_en = 4'b1101;
        cycles(2);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h0F0) begin
            errors++;
            $display("FAIL prio_l2: got %h expected %h", {VGA_R, VGA_G, VGA_B}, 12'h0F0);
        end
        layer_color[11:0] = 12'h123;
        layer_en = 4'b1111;
        cycles(2);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h123) begin
            errors++;
            $display("FAIL prio_l0: got %h expected %h", {VGA_R, VGA_G, VGA_B}, 12'h123);
        end
        layer_en = 4'b0000;
        cycles(2);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h00F) begin
            errors++;
            $display("FAIL prio_none_en: got %h expected %h", {VGA_R, VGA_G, VGA_B}, 12'h00F);
        end
    endtask

    task automatic test_transparent();
        trans_key = 12'h0F0;
        layer_color = {4{12'h0F0}};
        layer_en = 4'b1111;
        video_on_in = 1'b1;
        cycles(2);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h00F) begin
            errors++;
            $display("FAIL all_transparent_bg: got %h expected %h", {VGA_R, VGA_G, VGA_B}, 12'h00F);
        end
        video_on_in = 1'b0;
        hsync_in = 1'b0;
        cycles(2);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000 || hsync_out !== 1'b0) begin
            errors++;
            $display("FAIL blank_rgb_hsync: got %h/%b expected 000/0", {VGA_R, VGA_G, VGA_B}, hsync_out);
        end
        hsync_in = 1'b1;
        cycles(2);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000 || hsync_out !== 1'b1) begin
            errors++;
            $display("FAIL blank_hsync_back: got %h/%b expected 000/1", {VGA_R, VGA_G, VGA_B}, hsync_out);
        end
        video_on_in = 1'b1;
    endtask

    task automatic test_sync_latency();
        logic h_hist [0:39];
        logic v_hist [0:39];
        for (int k = 0; k < 40; k++) begin
            if (k >= 2) begin
                checks++;
                if (hsync_out !== h_hist[k-2] || vsync_out !== v_hist[k-2]) begin
                    errors++;
                    $display("FAIL sync_delay k=%0d: got %b%b expected %b%b",
                             k, hsync_out, vsync_out, h_hist[k-2], v_hist[k-2]);
                end
            end
            h_hist[k] = 1'($urandom_range(0, 1));
            v_hist[k] = 1'($urandom_range(0, 1));
            hsync_in = h_hist[k];
            vsync_in = v_hist[k];
            cycles(1);
        end
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        cycles(2);
    endtask

    task automatic test_fade_out();
        do_reset();
        trans_key = 12'h000;
        layer_color = {12'h000, 12'h000, 12'hFFF, 12'h000};
        layer_en = 4'b0010;
        video_on_in = 1'b1;
        cycles(3);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'hFFF || fade_busy !== 1'b0) begin
            errors++;
            $display("FAIL fade_full_pass: got %h/%b expected fff/0", {VGA_R, VGA_G, VGA_B}, fade_busy);
        end
        fade_start = 1'b1;
        cycles(1);
        fade_start = 1'b0;
        checks++;
        if (fade_busy !== 1'b1) begin
            errors++;
            $display("FAIL fade_out_busy: got %b expected 1", fade_busy);
        end
        frame_ticks(2);
        cycles(2);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'hEEE) begin
            errors++;
            $display("FAIL fade_out_2ticks: got %h expected %h", {VGA_R, VGA_G, VGA_B}, 12'hEEE);
        end
        frame_ticks(9);
        fade_start = 1'b1;
        cycles(1);
        fade_start = 1'b0;
        checks++;
        if (fade_busy !== 1'b1) begin
            errors++;
            $display("FAIL fade_out_restart_busy: got %b expected 1", fade_busy);
        end
        frame_ticks(5);
        cycles(2);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h777) begin
            errors++;
            $display("FAIL fade_out_16ticks: got %h expected %h", {VGA_R, VGA_G, VGA_B}, 12'h777);
        end
        frame_ticks(15);
        checks++;
        if (fade_busy !== 1'b1) begin
            errors++;
            $display("FAIL fade_out_31ticks_busy: got %b expected 1", fade_busy);
        end
        frame_ticks(1);
        cycles(2);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000 || fade_busy !== 1'b0) begin
            errors++;
            $display("FAIL fade_out_dark: got %h/%b expected 000/0", {VGA_R, VGA_G, VGA_B}, fade_busy);
        end
    endtask

    task automatic test_fade_in_reset();
        fade_start = 1'b1;
        vsync_in = 1'b0;
        cycles(1);
        fade_start = 1'b0;
        vsync_in = 1'b1;
        checks++;
        if (fade_busy !== 1'b1) begin
            errors++;
            $display("FAIL fade_in_busy: got %b expected 1", fade_busy);
        end
        cycles(1);
        hsync_in = 1'b0;
        frame_ticks(21);
        cycles(2);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h999) begin
            errors++;
            $display("FAIL fade_in_21ticks: got %h expected %h", {VGA_R, VGA_G, VGA_B}, 12'h999);
        end
        frame_ticks(1);
        cycles(2);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'hAAA || hsync_out !== 1'b0) begin
            errors++;
            $display("FAIL fade_in_22ticks: got %h/%b expected aaa/0", {VGA_R, VGA_G, VGA_B}, hsync_out);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000 || fade_busy !== 1'b0 ||
            hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got %h/%b/%b%b expected 000/0/11",
                     {VGA_R, VGA_G, VGA_B}, fade_busy, hsync_out, vsync_out);
        end
        hsync_in = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(3);
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'hFFF || fade_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_full: got %h/%b expected fff/0", {VGA_R, VGA_G, VGA_B}, fade_busy);
        end
    endtask

`ifdef VGA_BLINK_EN
    task automatic test_blink();
        logic [11:0] exp_c;
        do_reset();
        trans_key = 12'h000;
        layer_color = {12'h000, 12'h000, 12'h333, 12'hFFF};
        layer_en = 4'b0011;
        video_on_in = 1'b1;
        cycles(2);
        for (int f = 0; f <= 6; f++) begin
            exp_c = (f >= 3 && f <= 5) ? 12'h333 : 12'hFFF;
            checks++;
            if ({VGA_R, VGA_G, VGA_B} !== exp_c) begin
                errors++;
                $display("FAIL blink_frame%0d: got %h expected %h", f, {VGA_R, VGA_G, VGA_B}, exp_c);
            end
            frame_ticks(1);
            cycles(2);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_priority();
        test_transparent();
        test_sync_latency();
        test_fade_out();
        test_fade_in_reset();
`ifdef VGA_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
